// File: rtl/dcdl_lock_monitor_if.sv
// Bundle between the tap controller side and the lock monitor: the thermometer
// word pair, control inputs, and the decoded status the monitor reports back.
interface dcdl_lock_monitor_if #(
    parameter int TW = 16,
    parameter int CW = 5
);
    logic          en;
    logic [TW-1:0] T;
    logic [TW-1:0] Tb;
    logic          clr_err;
    logic [CW-1:0] code;
    logic          code_valid;
    logic          err_comp;
    logic          err_bubble;
    logic          err_seen;
    logic          lock;
    logic          lock_lost;

    modport master (
        output en, T, Tb, clr_err,
        input  code, code_valid, err_comp, err_bubble, err_seen, lock, lock_lost
    );

    modport slave (
        input  en, T, Tb, clr_err,
        output code, code_valid, err_comp, err_bubble, err_seen, lock, lock_lost
    );
endinterface

// File: rtl/dcdl_lock_monitor.sv
// Receive-side checker for the delay-line thermometer word: two-stage capture,
// complement/bubble checks with binary decode, and a tolerance-based lock FSM.
module dcdl_lock_monitor #(
    parameter int TW       = 16,
    parameter int CW       = 5,
    parameter int LOCK_CNT = 8,
    parameter int TOL      = 1,
    parameter int MISS_MAX = 2
) (
    input  logic               clk_ext,
    input  logic               rst_n,
    dcdl_lock_monitor_if.slave mon
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    logic [TW-1:0] t_r, tb_r;
    logic [CW-1:0] code_q;
    logic          valid_q, comp_q, bubble_q, seen_q;

    logic          comp_c, bubble_c;
    logic [CW-1:0] ones_c;

    always_comb begin
        comp_c   = (tb_r != ~t_r);
        // A 0 below a 1 anywhere means the word is not a clean thermometer fill.
        bubble_c = |(t_r[TW-1:1] & ~t_r[TW-2:0]);
        ones_c   = '0;
        for (int i = 0; i < TW; i++) ones_c = ones_c + CW'(t_r[i]);
    end

    // NOTE: every register below uses non-blocking assignments so all stages
    // sample their inputs from the same edge regardless of statement order.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            t_r      <= '0;
            tb_r     <= '0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            comp_q   <= 1'b0;
            bubble_q <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            t_r      <= mon.T;
            tb_r     <= mon.Tb;
            comp_q   <= comp_c;
            bubble_q <= bubble_c;
            valid_q  <= !(comp_c || bubble_c);
            if (!(comp_c || bubble_c)) code_q <= ones_c;
            if (comp_c || bubble_c) seen_q <= 1'b1;
            else if (mon.clr_err)   seen_q <= 1'b0;
        end
    end

    state_t        state_q, state_n;
    logic [CW-1:0] ref_q, ref_n;
    logic [7:0]    cnt_q, cnt_n;
    logic [3:0]    miss_q, miss_n;
    logic          lock_q, lock_n, lost_q, lost_n;

    logic [CW:0]   diff;
    logic          in_tol;

    // Operands are widened by one bit so the subtraction never wraps.
    always_comb begin
        if (code_q >= ref_q) diff = {1'b0, code_q} - {1'b0, ref_q};
        else                 diff = {1'b0, ref_q} - {1'b0, code_q};
        in_tol = valid_q && (diff <= (CW+1)'(TOL));
    end

    // NOTE: every next-state variable gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_n = state_q;
        ref_n   = ref_q;
        cnt_n   = cnt_q;
        miss_n  = miss_q;
        lock_n  = lock_q;
        lost_n  = 1'b0;
        if (!mon.en) begin
            state_n = IDLE;
            cnt_n   = '0;
            miss_n  = '0;
            lock_n  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_n   = '0;
                    miss_n  = '0;
                    lock_n  = 1'b0;
                    state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    if (!valid_q) begin
                        cnt_n = '0;
                    end else begin
                        if (cnt_q == 8'd0 || !in_tol) begin
                            ref_n = code_q;
                            cnt_n = 8'd1;
                        end else begin
                            cnt_n = cnt_q + 8'd1;
                        end
                        if (cnt_n == 8'(LOCK_CNT)) begin
                            state_n = LOCKED;
                            lock_n  = 1'b1;
                            miss_n  = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (in_tol) begin
                        miss_n = '0;
                    end else begin
                        miss_n = miss_q + 4'd1;
                        if (miss_n == 4'(MISS_MAX)) begin
                            state_n = ACQUIRE;
                            cnt_n   = '0;
                            miss_n  = '0;
                            lock_n  = 1'b0;
                            lost_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ref_q   <= '0;
            cnt_q   <= '0;
            miss_q  <= '0;
            lock_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ref_q   <= ref_n;
            cnt_q   <= cnt_n;
            miss_q  <= miss_n;
            lock_q  <= lock_n;
            lost_q  <= lost_n;
        end
    end

    assign mon.code       = code_q;
    assign mon.code_valid = valid_q;
    assign mon.err_comp   = comp_q;
    assign mon.err_bubble = bubble_q;
    assign mon.err_seen   = seen_q;
    assign mon.lock       = lock_q;
    assign mon.lock_lost  = lost_q;

endmodule

// File: tb/tb_dcdl_lock_monitor.sv
// Randomized and directed bench for dcdl_lock_monitor against a cycle-level
// behavioural model of the monitor's rules.
module tb_dcdl_lock_monitor;
    localparam int TW = 16, CW = 5, LOCK_CNT = 8, TOL = 1, MISS_MAX = 2;

    logic clk_ext = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_ext = ~clk_ext;

    dcdl_lock_monitor_if #(.TW(TW), .CW(CW)) mon_if ();

    dcdl_lock_monitor #(.TW(TW), .CW(CW), .LOCK_CNT(LOCK_CNT), .TOL(TOL), .MISS_MAX(MISS_MAX)) dut (
        .clk_ext (clk_ext),
        .rst_n   (rst_n),
        .mon     (mon_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum {M_IDLE, M_ACQ, M_LOCK} mstate_t;
    mstate_t       m_st;
    logic [TW-1:0] m_t1, m_tb1;
    int            m_code, m_ref, m_cnt, m_miss;
    bit            m_valid, m_comp, m_bub, m_seen, m_lock, m_lost;

    function automatic logic [TW-1:0] thermo(int n);
        logic [TW:0] x;
        x = (TW+1)'(1) << n;
        return TW'(x - 1);
    endfunction

    function automatic int absdiff(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [10:0] dut_vec();
        return {mon_if.code, mon_if.code_valid, mon_if.err_comp, mon_if.err_bubble,
                mon_if.err_seen, mon_if.lock, mon_if.lock_lost};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {5'(m_code), m_valid, m_comp, m_bub, m_seen, m_lock, m_lost};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_t1 = '0; m_tb1 = '0;
        m_code = 0; m_ref = 0; m_cnt = 0; m_miss = 0;
        m_valid = 0; m_comp = 0; m_bub = 0; m_seen = 0; m_lock = 0; m_lost = 0;
    endtask

    // One clock edge of the specified behaviour; FSM sees last edge's decode.
    task automatic model_edge();
        bit good;
        int ones;
        good   = m_valid && (absdiff(m_code, m_ref) <= TOL);
        m_lost = 0;
        if (!mon_if.en) begin
            m_st = M_IDLE; m_lock = 0; m_cnt = 0; m_miss = 0;
        end else if (m_st == M_IDLE) begin
            m_st = M_ACQ;
        end else if (m_st == M_ACQ) begin
            if (!m_valid) m_cnt = 0;
            else begin
                if (m_cnt == 0 || !good) begin m_ref = m_code; m_cnt = 1; end
                else m_cnt++;
                if (m_cnt == LOCK_CNT) begin m_st = M_LOCK; m_lock = 1; m_miss = 0; end
            end
        end else begin
            if (good) m_miss = 0;
            else begin
                m_miss++;
                if (m_miss == MISS_MAX) begin
                    m_st = M_ACQ; m_cnt = 0; m_lock = 0; m_lost = 1;
                end
            end
        end
        ones    = $countones(m_t1);
        m_comp  = (m_tb1 != ~m_t1);
        m_bub   = (m_t1 != thermo(ones));
        m_valid = !m_comp && !m_bub;
        if (m_valid) m_code = ones;
        m_seen  = (m_comp || m_bub) ? 1'b1 : (mon_if.clr_err ? 1'b0 : m_seen);
        m_t1    = mon_if.T;
        m_tb1   = mon_if.Tb;
    endtask

    task automatic step();
        @(posedge clk_ext);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [TW-1:0] t);
        mon_if.T  = t;
        mon_if.Tb = ~t;
    endtask

    task automatic test_reset();
        mon_if.en = 1'b0; mon_if.T = '0; mon_if.Tb = '0; mon_if.clr_err = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_ext);
        #1;
        n_checks++;
        if (dut_vec() !== 11'd0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", dut_vec());
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if (mon_if.err_comp !== 1'b1) begin
            n_fail++; $display("FAIL reset_err_comp: got %b want 1", mon_if.err_comp);
        end
        drive('0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL reset_flush[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic_lock();
        int rise = -1;
        mon_if.en = 1'b1;
        step();
        drive(16'h00FF);
        for (int i = 0; i < 12; i++) begin
            mon_if.clr_err = (i == 3);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL basic_lock[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (mon_if.lock && rise < 0) rise = i;
        end
        mon_if.clr_err = 1'b0;
        n_checks++;
        if (rise !== 9) begin n_fail++; $display("FAIL basic_lock_edge: got %0d want 9", rise); end
        n_checks++;
        if ({mon_if.code, mon_if.code_valid, mon_if.err_seen} !== {5'd8, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL basic_lock_code: got code=%0d valid=%b seen=%b want 8/1/0",
                               mon_if.code, mon_if.code_valid, mon_if.err_seen);
        end
    endtask

    task automatic test_tolerance();
        bit lost_seen = 0, unlocked = 0;
        for (int i = 0; i < 20; i++) begin
            drive((i % 2) ? 16'h01FF : 16'h007F);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL tolerance[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            lost_seen |= mon_if.lock_lost;
            unlocked  |= !mon_if.lock;
        end
        n_checks++;
        if ({lost_seen, unlocked} !== 2'b00) begin
            n_fail++; $display("FAIL tolerance_hold: got lost=%b unlocked=%b want 0/0", lost_seen, unlocked);
        end
    endtask

    task automatic test_jump();
        logic [TW-1:0] seq [10] = '{16'h0FFF, 16'h00FF, 16'h0FFF, 16'h00FF, 16'h00FF,
                                    16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};
        bit lost_seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(seq[i]);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL jump[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            lost_seen |= mon_if.lock_lost;
        end
        n_checks++;
        if ({mon_if.lock, lost_seen} !== 2'b10) begin
            n_fail++; $display("FAIL jump_hold: got lock=%b lost=%b want 1/0", mon_if.lock, lost_seen);
        end
    endtask

    task automatic test_sustained_jump();
        int lost_at = -1, pulses = 0, relock_at = -1;
        drive(16'h0FFF);
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL sustained[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (mon_if.lock_lost) begin pulses++; if (lost_at < 0) lost_at = i; end
            if (lost_at >= 0 && i > lost_at && mon_if.lock && relock_at < 0) relock_at = i;
        end
        n_checks++;
        if ({pulses, lost_at, relock_at - lost_at} !== {32'd1, 32'd3, 32'd8}) begin
            n_fail++; $display("FAIL sustained_timing: got pulses=%0d lost=%0d relock_gap=%0d want 1/3/8",
                               pulses, lost_at, relock_at - lost_at);
        end
        n_checks++;
        if ({mon_if.code, mon_if.lock} !== {5'd12, 1'b1}) begin
            n_fail++; $display("FAIL sustained_relock: got code=%0d lock=%b want 12/1", mon_if.code, mon_if.lock);
        end
    endtask

    task automatic test_errors();
        mon_if.en = 1'b0; step();
        mon_if.en = 1'b1; drive(16'h00FF);
        repeat (4) step();
        drive(16'h00F7);
        step();
        drive(16'h00FF);
        step();
        n_checks++;
        if ({mon_if.err_bubble, mon_if.code_valid, mon_if.code, mon_if.err_seen} !== {1'b1, 1'b0, 5'd8, 1'b1}) begin
            n_fail++; $display("FAIL bubble: got bub=%b valid=%b code=%0d seen=%b want 1/0/8/1",
                               mon_if.err_bubble, mon_if.code_valid, mon_if.code, mon_if.err_seen);
        end
        mon_if.Tb = 16'hFF01;
        step();
        mon_if.Tb = 16'hFF00;
        step();
        n_checks++;
        if ({mon_if.err_comp, mon_if.err_bubble, mon_if.code_valid} !== 3'b100) begin
            n_fail++; $display("FAIL comp: got comp=%b bub=%b valid=%b want 1/0/0",
                               mon_if.err_comp, mon_if.err_bubble, mon_if.code_valid);
        end
        for (int i = 0; i < 12; i++) begin
            mon_if.clr_err = (i == 6);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL errors_track[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i == 5) begin
                n_checks++;
                if (mon_if.err_seen !== 1'b1) begin
                    n_fail++; $display("FAIL err_seen_sticky: got %b want 1", mon_if.err_seen);
                end
            end
        end
        mon_if.clr_err = 1'b0;
        n_checks++;
        if (mon_if.err_seen !== 1'b0) begin
            n_fail++; $display("FAIL err_seen_clear: got %b want 0", mon_if.err_seen);
        end
    endtask

    task automatic test_boundaries();
        int rise = -1;
        mon_if.en = 1'b0; step();
        mon_if.en = 1'b1; drive(16'h0000);
        repeat (4) step();
        n_checks++;
        if ({mon_if.code, mon_if.code_valid} !== {5'd0, 1'b1}) begin
            n_fail++; $display("FAIL boundary_zero: got code=%0d valid=%b want 0/1", mon_if.code, mon_if.code_valid);
        end
        drive(16'hFFFF);
        for (int i = 0; i < 14; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL boundary[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (mon_if.lock && rise < 0) rise = i;
        end
        n_checks++;
        if ({mon_if.code, mon_if.code_valid, rise} !== {5'd16, 1'b1, 32'd9}) begin
            n_fail++; $display("FAIL boundary_full: got code=%0d valid=%b rise=%0d want 16/1/9",
                               mon_if.code, mon_if.code_valid, rise);
        end
    endtask

    task automatic test_en_drop();
        mon_if.en = 1'b0;
        step();
        n_checks++;
        if ({mon_if.lock, mon_if.lock_lost} !== 2'b00) begin
            n_fail++; $display("FAIL en_drop: got lock=%b lost=%b want 0/0", mon_if.lock, mon_if.lock_lost);
        end
        mon_if.en = 1'b1;
        for (int i = 0; i < 30 && !mon_if.lock; i++) step();
        n_checks++;
        if (mon_if.lock !== 1'b1) begin
            n_fail++; $display("FAIL en_relock: got lock=%b want 1", mon_if.lock);
        end
        drive(16'h0000);
        repeat (3) step();
        mon_if.en = 1'b0;
        step();
        n_checks++;
        if ({mon_if.lock, mon_if.lock_lost} !== 2'b00 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL en_drop_simul: got %h want %h (lock=0 lost=0)", dut_vec(), exp_vec());
        end
        mon_if.en = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        int guard;
        drive(16'hFFFF);
        repeat (3) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== 11'd0) begin
            n_fail++; $display("FAIL reset_mid_acq: got %h want 0", dut_vec());
        end
        @(posedge clk_ext); #1 rst_n = 1'b1;
        for (int i = 0; i < 30 && !mon_if.lock; i++) step();
        drive(16'h0000);
        guard = 0;
        while (!mon_if.lock_lost && guard < 8) begin step(); guard++; end
        n_checks++;
        if (mon_if.lock_lost !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_pulse_setup: got lost=%b want 1", mon_if.lock_lost);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== 11'd0) begin
            n_fail++; $display("FAIL reset_mid_lost: got %h want 0", dut_vec());
        end
        @(posedge clk_ext); #1 rst_n = 1'b1;
    endtask

    task automatic test_random();
        int base = 8, c, r;
        logic [TW-1:0] t;
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65) begin
                c = base + int'($urandom_range(0, 2)) - 1;
                if (c < 0) c = 0;
                if (c > TW) c = TW;
                drive(thermo(c));
            end else if (r < 78) begin
                base = int'($urandom_range(0, TW));
                drive(thermo(base));
            end else if (r < 86) begin
                t = TW'($urandom);
                drive(t);
            end else if (r < 93) begin
                t = thermo(base);
                mon_if.T  = t;
                mon_if.Tb = ~t ^ (TW'(1) << $urandom_range(0, TW-1));
            end else begin
                drive(thermo(int'($urandom_range(0, TW))));
            end
            mon_if.en      = ($urandom_range(0, 99) >= 2);
            mon_if.clr_err = ($urandom_range(0, 99) < 6);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        mon_if.en = 1'b1; mon_if.clr_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_lock();
        test_tolerance();
        test_jump();
        test_sustained_jump();
        test_errors();
        test_boundaries();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dcdl_lock_monitor.md
# dcdl_lock_monitor

Receive-side checker for the thermometer control word that the phase/tap controller drives into the digitally controlled delay line. Runs on `clk_ext`.
- Registers `T`/`Tb`, checks them for complement and bubble errors, and decodes the valid tap count to binary.
- A lock state machine declares lock once the decoded tap count has held within a tolerance for a programmable number of samples.
- Sits beside the delay line in the FMDLL top. It gives the frequency-multiplying loop a lock indication and a debug view of the tap code.

## Interface
- `TW`, 16: thermometer width; must match the delay-line `T`/`Tb` width.
- `CW`, 5: decoded code width, equal to $clog2(TW+1).
- `LOCK_CNT`, 8: consecutive in-tolerance valid samples required for lock (2..255).
- `TOL`, 1: allowed |code − ref| while acquiring and while locked.
- `MISS_MAX`, 2: consecutive violations in LOCKED before lock is dropped (1..15).

Ports:
- `clk_ext`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  monitor enable; low forces IDLE.
- `T`  in  TW  thermometer tap code, ones fill from LSB.
- `Tb`  in  TW  complement of `T`.
- `clr_err`  in  1  synchronous clear of `err_seen`.
- `code`  out  CW  decoded tap count, 0..TW.
- `code_valid`  out  1  `code` is from a legal word this cycle.
- `err_comp`  out  1  `Tb` != ~`T` this sample.
- `err_bubble`  out  1  `T` not of form 0…01…1 this sample.
- `err_seen`  out  1  sticky OR of both error flags.
- `lock`  out  1  loop locked.
- `lock_lost`  out  1  one-cycle pulse when leaving LOCKED.

## Operation
- **Stage 1:** register `T` and `Tb` every cycle. No enable gating.
- **Stage 2:** register the check and decode results.
  - `err_comp` = (Tb_r != ~T_r).
  - `err_bubble` is set when any bit i>0 has T_r[i]=1 and T_r[i-1]=0.
  - `code_valid` = !err_comp && !err_bubble.
  - `code` = number of ones in T_r when valid; otherwise `code` holds its previous value.
  - All-zeros (code 0) and all-ones (code TW) are legal words.
- **`err_seen` priority:** set on any stage-2 error; `clr_err` in the same cycle as an error leaves it set.
- **Difference rule:** compute |code − ref| on CW+1-bit unsigned operands. There is no wrap: codes 0 and TW differ by TW.
- **FSM states:** IDLE, ACQUIRE, LOCKED. Registers: `ref` (CW bits), `cnt` (8-bit), `miss` (4-bit).
- **IDLE:** `lock`=0, `cnt`=0, `miss`=0. If `en`=1, go to ACQUIRE next cycle.
- **ACQUIRE:** evaluated on each stage-2 sample.
  - Invalid sample: `cnt`←0.
  - Valid sample with `cnt`=0 or diff>TOL: `ref`←`code`, `cnt`←1.
  - Otherwise: `cnt`←`cnt`+1.
  - When the incremented `cnt` equals LOCK_CNT: go to LOCKED, `lock`←1, `miss`←0.
- **LOCKED:** `ref` is frozen.
  - Valid sample with diff≤TOL: `miss`←0.
  - Otherwise: `miss`←`miss`+1.
  - When `miss`+1 = MISS_MAX: go to ACQUIRE with `cnt`←0 and `lock`←0, and pulse `lock_lost` for one cycle.
- **`en`=0 in any state:** synchronous move to IDLE, `lock`←0. No `lock_lost` pulse on this disable path.
- **Counters:** `cnt` saturates and cannot exceed LOCK_CNT; `miss` cannot exceed MISS_MAX.

## Timing
- **Reset values:** all outputs 0, state IDLE, `ref`=0, pipeline registers 0. The zero-reset pipeline decodes as legal all-zeros `T` with `Tb`=0, so `err_comp` becomes 1 one cycle after reset release if inputs are still zero.
- **Latency:** `T`/`Tb` captured at edge k give `code`, `code_valid` and error flags after edge k+1. The FSM consumes them at edge k+2.
- **Lock rise:** with stable legal input from edge 0 and the FSM already in ACQUIRE, `lock` rises after edge LOCK_CNT+1.
- **Lock fall:** MISS_MAX consecutive bad words captured at edges j..j+MISS_MAX−1 drop `lock` after edge j+MISS_MAX+1, with `lock_lost` high for that one cycle.
- **Reset mid-operation:** asynchronous `rst_n` low clears everything immediately, including an in-flight `lock_lost` pulse.
- **Simultaneous events:** `en` falling in the same cycle as a lock-drop condition gives IDLE with no `lock_lost` pulse.

## Test plan
- **Basic lock:** reset, `en`=1, drive T=16'h00FF and Tb=16'hFF00 constant.
  - Required: `code`=8, `code_valid`=1, `lock` rises exactly 9 edges after the first capture, `err_seen`=0.
- **Tolerance:** while locked, alternate T between 16'h007F and 16'h01FF.
  - Required: `lock` stays 1, `lock_lost` never pulses.
- **Jump:** while locked, apply T=16'h0FFF for 1 cycle, then return to 16'h00FF.
  - Required: `lock` stays 1, `miss` returns to 0.
- **Sustained jump:** apply T=16'h0FFF for 2 cycles.
  - Required: `lock_lost` is a 1-cycle pulse, `lock`=0, then re-lock on code 12 after 8 more valid samples.
- **Error detection:**
  - T=16'h00F7 with a correct Tb: `err_bubble`=1, `code` unchanged, `cnt` cleared in ACQUIRE.
  - Tb=16'hFF01 with T=16'h00FF: `err_comp`=1.
  - `err_seen` stays 1 until `clr_err` is pulsed.
- **Boundaries and control:**
  - T=0/Tb=FFFF gives `code`=0; T=FFFF/Tb=0 gives `code`=16. A step from 0 to 16 counts as out of tolerance.
  - Dropping `en` while locked gives `lock`=0 next cycle with no pulse.
  - Asserting `rst_n` low mid-acquire clears all outputs asynchronously.
